// File: rtl/mem_access_stage.sv
// mem_access_stage
//   Memory-access pipeline stage between execute and register-file writeback.
//   Issues loads/stores on a req/gnt/rvalid data-memory port, aligns and
//   extends load data, selects the writeback value, and stalls upstream while
//   a memory transaction is outstanding.
//
// Ports
//   clk, rstn            clock, asynchronous active-low reset
//   ex_*                 registered execute-stage outputs (held while stall_o)
//   dmem_req/we/addr/be/wdata   data-memory request (combinational)
//   dmem_gnt/rvalid/rdata       data-memory grant and load response
//   stall_o              upstream must hold ex_* stable
//   wb_reg_wr/rd_addr/data      registered writeback
//   misaligned_o         registered one-cycle pulse for a dropped misaligned op
module mem_access_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned RF_AW = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [XLEN-1:0]  ex_alu_out,
  input  logic [XLEN-1:0]  ex_rs2_data,
  input  logic [RF_AW-1:0] ex_rd_addr,
  input  logic [XLEN-1:0]  ex_pc_pls4,
  input  logic             ex_reg_wr,
  input  logic [1:0]       ex_wb_sel,
  input  logic             ex_dmem_req,
  input  logic             ex_dmem_write,
  input  logic             ex_dmem_l_unsigned,
  input  logic [1:0]       ex_dmem_n_bytes,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [XLEN-1:0]  dmem_addr,
  output logic [3:0]       dmem_be,
  output logic [XLEN-1:0]  dmem_wdata,
  input  logic             dmem_gnt,
  input  logic             dmem_rvalid,
  input  logic [XLEN-1:0]  dmem_rdata,
  output logic             stall_o,
  output logic             wb_reg_wr,
  output logic [RF_AW-1:0] wb_rd_addr,
  output logic [XLEN-1:0]  wb_data,
  output logic             misaligned_o
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

  state_t            r_state;
  logic              w_is_byte;
  logic              w_is_half;
  logic              w_aligned;
  logic              w_mem_op;
  logic              w_misal;
  logic              w_complete;
  logic [XLEN-1:0]   w_shifted;
  logic [XLEN-1:0]   w_load_ext;
  logic [XLEN-1:0]   w_wb_val;

  always_comb begin
    w_is_byte = (ex_dmem_n_bytes == 2'd0);
    w_is_half = (ex_dmem_n_bytes == 2'd1);
    w_aligned = w_is_byte
              | (w_is_half & ~ex_alu_out[0])
              | (~w_is_byte & ~w_is_half & (ex_alu_out[1:0] == 2'b00));
    w_mem_op  = ex_dmem_req & w_aligned;
    w_misal   = ex_dmem_req & ~w_aligned;
  end

  // Store lane steering; address is stable for the whole transaction because
  // upstream holds ex_* while stalled.
  always_comb begin
    dmem_we    = ex_dmem_write;
    dmem_addr  = {ex_alu_out[XLEN-1:2], 2'b00};
    dmem_be    = 4'b1111;
    dmem_wdata = ex_rs2_data;
    if (w_is_byte) begin
      dmem_be    = 4'b0001 << ex_alu_out[1:0];
      dmem_wdata = {4{ex_rs2_data[7:0]}};
    end else if (w_is_half) begin
      dmem_be    = 4'b0011 << ex_alu_out[1:0];
      dmem_wdata = {2{ex_rs2_data[15:0]}};
    end
  end

  // Request is gated by rstn so nothing leaks out while reset is held.
  always_comb begin
    w_complete = 1'b0;
    dmem_req   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        dmem_req   = rstn & w_mem_op;
        w_complete = ~w_mem_op | (dmem_gnt & ex_dmem_write);
      end
      S_REQ: begin
        dmem_req   = rstn;
        w_complete = dmem_gnt & ex_dmem_write;
      end
      S_RESP: begin
        w_complete = dmem_rvalid;
      end
      default: begin
        w_complete = 1'b0;
      end
    endcase
    stall_o = ~w_complete;
  end

  always_comb begin
    w_shifted  = dmem_rdata >> {ex_alu_out[1:0], 3'b000};
    w_load_ext = dmem_rdata;
    if (w_is_byte) begin
      w_load_ext = ex_dmem_l_unsigned ? {24'd0, w_shifted[7:0]}
                                      : {{24{w_shifted[7]}}, w_shifted[7:0]};
    end else if (w_is_half) begin
      w_load_ext = ex_dmem_l_unsigned ? {16'd0, w_shifted[15:0]}
                                      : {{16{w_shifted[15]}}, w_shifted[15:0]};
    end
    unique case (ex_wb_sel)
      2'd1:    w_wb_val = w_load_ext;
      2'd2:    w_wb_val = ex_pc_pls4;
      default: w_wb_val = ex_alu_out;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= S_IDLE;
      wb_reg_wr    <= 1'b0;
      wb_rd_addr   <= '0;
      wb_data      <= '0;
      misaligned_o <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_mem_op) begin
            if (dmem_gnt) r_state <= ex_dmem_write ? S_IDLE : S_RESP;
            else          r_state <= S_REQ;
          end
        end
        S_REQ: begin
          if (dmem_gnt) r_state <= ex_dmem_write ? S_IDLE : S_RESP;
        end
        S_RESP: begin
          if (dmem_rvalid) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      misaligned_o <= (r_state == S_IDLE) & w_misal;

      // Stores and dropped misaligned ops complete without writing rd.
      if (w_complete) begin
        wb_reg_wr  <= ex_reg_wr & ~(ex_dmem_req & (ex_dmem_write | ~w_aligned));
        wb_rd_addr <= ex_rd_addr;
        wb_data    <= w_wb_val;
      end else begin
        wb_reg_wr  <= 1'b0;
      end
    end
  end

endmodule
